ram_be_clr: RTL and testbench

- Parametrised single-port synchronous RAM for the memory subsystem, succeeding the fixed 16-bit lower-byte RAM.
- Adds per-byte write enables and a selectable combinational or registered read port.
- Adds a hardware clear engine that zeroes every word after reset and on request. Contents are therefore defined without relying on simulation-only initialisation.
- Sits between the CPU load/store path and the data/video memory map.

---
 rtl/ram_be_clr.sv | 118 +++++++++++
 tb/tb_ram_be_clr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_be_clr.sv
// ram_be_clr: single-port synchronous RAM with per-byte write enables, a
// selectable combinational or registered read port, and a clear engine that
// zeroes every word after reset and on request.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (restarts the clear sweep)
//   addr  - word address for read and write
//   d     - write data
//   we    - write strobe (ignored while busy)
//   be    - byte enables, be[k] gates d[8k+7:8k]
//   clr   - clear request pulse (ignored while busy, wins over we)
//   busy  - high while the clear sweep runs
//   q     - read data, forced to zero while busy
module ram_be_clr #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_REG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   d,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr,
  output logic                busy,
  output logic [DATA_W-1:0]   q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                user_wr;

  logic [DATA_W-1:0]   mem [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      CLEAR: begin
        // cnt wraps to zero naturally on the last word
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          // Last word is being zeroed on this very edge; do not capture its
          // stale contents into the read register.
          rdata_d = (addr == cnt_q) ? '0 : mem[addr];
        end else begin
          rdata_d = '0;
        end
      end
      IDLE: begin
        rdata_d = mem[addr];
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q == CLEAR);
    user_wr = (state_q == IDLE) && we && !clr;
    if (busy) begin
      q = '0;
    end else if (READ_REG != 0) begin
      q = rdata_q;
    end else begin
      q = mem[addr];
    end
  end

  // Storage array: not reset, the sweep defines its contents
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (user_wr) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) begin
          mem[addr][k*8 +: 8] <= d[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_be_clr.sv
// Randomised scoreboard bench for ram_be_clr: one combinational-read and one
// registered-read instance share the same stimulus and are compared against
// a word-array reference model.
module tb_ram_be_clr;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic              we;
  logic [1:0]        be;
  logic              clr;
  logic              busy0, busy1;
  logic [DATA_W-1:0] q0, q1;

  ram_be_clr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .addr(addr), .d(d), .we(we), .be(be),
    .clr(clr), .busy(busy0), .q(q0)
  );

  ram_be_clr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .addr(addr), .d(d), .we(we), .be(be),
    .clr(clr), .busy(busy1), .q(q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  a;
    logic        busy;
    logic [15:0] q0;
    logic [15:0] q1;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: words, remaining busy cycles, registered read value
  logic [15:0] mem_m [DEPTH];
  int          busy_left = DEPTH;
  logic [15:0] rq_m = '0;

  task automatic check(input string name, input int c, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present busy/q; pop and compare
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("busy_comb", e.cyc, {15'd0, busy0}, {15'd0, e.busy});
      check("busy_reg",  e.cyc, {15'd0, busy1}, {15'd0, e.busy});
      check("q_comb",    e.cyc, q0, e.q0);
      check("q_reg",     e.cyc, q1, e.q1);
    end
  end

  // One clock cycle of stimulus; called just after a rising edge
  task automatic cycle(input logic r, input logic [3:0] a, input logic [15:0] dd,
                       input logic w, input logic [1:0] b, input logic c);
    exp_t e;
    rst_n = ~r; addr = a; d = dd; we = w; be = b; clr = c;
    if (r) begin
      busy_left = DEPTH;
      rq_m = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end
    e.cyc  = cyc;
    e.a    = a;
    e.busy = (busy_left != 0);
    e.q0   = e.busy ? 16'h0 : mem_m[a];
    e.q1   = e.busy ? 16'h0 : rq_m;
    sb.push_back(e);
    @(posedge clk);
    cyc++;
    if (!r) begin
      rq_m = mem_m[a];
      if (busy_left != 0) begin
        busy_left--;
      end else if (c) begin
        // The whole array reads as zero once the sweep completes
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        busy_left = DEPTH;
      end else if (w) begin
        if (b[0]) mem_m[a] = {mem_m[a][15:8], dd[7:0]};
        if (b[1]) mem_m[a] = {dd[15:8], mem_m[a][7:0]};
      end
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] a);
    cycle(1'b0, a, 16'h0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; d = '0; we = 1'b0; be = '0; clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    @(posedge clk); #1;

    // Power-up: reset held, then the 16-cycle sweep, then read every word
    cycle(1'b1, 4'd0, 16'h0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 18; i++) idle(4'(i));
    for (int i = 0; i < 16; i++) idle(4'(i));

    // Byte enables
    cycle(1'b0, 4'd3, 16'hABCD, 1'b1, 2'b01, 1'b0);
    idle(4'd3);
    cycle(1'b0, 4'd3, 16'h1234, 1'b1, 2'b10, 1'b0);
    idle(4'd3);
    idle(4'd3);
    cycle(1'b0, 4'd3, 16'hFFFF, 1'b1, 2'b00, 1'b0);
    idle(4'd3);
    idle(4'd3);

    // Registered read-during-write returns old data
    cycle(1'b0, 4'd7, 16'h5A5A, 1'b1, 2'b11, 1'b0);
    idle(4'd7);
    idle(4'd7);

    // Fill, then clr together with a write: write dropped, full sweep
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'(i), 16'hFFFF, 1'b1, 2'b11, 1'b0);
    cycle(1'b0, 4'd2, 16'h1111, 1'b1, 2'b11, 1'b1);
    // Writes during busy are dropped
    for (int i = 0; i < 6; i++) idle(4'd5);
    cycle(1'b0, 4'd5, 16'hBEEF, 1'b1, 2'b11, 1'b0);
    cycle(1'b0, 4'd5, 16'hBEEF, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 10; i++) idle(4'd5);
    for (int i = 0; i < 16; i++) idle(4'(i));

    // Reset mid-sweep at cnt=9
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'(i), 16'h0F0F, 1'b1, 2'b11, 1'b0);
    cycle(1'b0, 4'd4, 16'h0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 9; i++) idle(4'd4);
    cycle(1'b1, 4'd4, 16'h0, 1'b0, 2'b00, 1'b0);
    cycle(1'b1, 4'd4, 16'h0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 18; i++) idle(4'd15);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 249) == 0),
            4'($urandom_range(0, 15)),
            16'($urandom),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 20; i++) idle(4'(i));

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
